// File: rtl/fdivsqrt_requester.sv
// fdivsqrt_requester: issues one div/rem/sqrt request to the divider and returns its result with a watchdog.
// Define FDIVSQRT_REQUESTER_PERF_EN to add the PerfOps/PerfWaitCycles counters.
module fdivsqrt_requester #(
  parameter int XLEN    = 64,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 128,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic            ReqIsInt,
  input  logic            ReqSqrt,
  input  logic [2:0]      ReqFunct3,
  input  logic            ReqW64,
  input  logic [XLEN-1:0] ReqSrcA,
  input  logic [XLEN-1:0] ReqSrcB,
  input  logic [TAGW-1:0] ReqTag,
  input  logic            Flush,
  output logic            FDivStartE,
  output logic            IDivStartE,
  output logic            IntDivE,
  output logic            SqrtE,
  output logic            W64E,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] ForwardedSrcAE,
  output logic [XLEN-1:0] ForwardedSrcBE,
  output logic            FlushE,
  input  logic            FDivBusyE,
  input  logic            FDivDoneE,
  input  logic [XLEN-1:0] FIntDivResultM,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] RspData,
  output logic [TAGW-1:0] RspTag,
  output logic            RspTimeout
`ifdef FDIVSQRT_REQUESTER_PERF_EN
  ,
  output logic [31:0]     PerfOps,
  output logic [31:0]     PerfWaitCycles
`endif
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic accept, timeout, to_hit, abort;
  logic unused_busy;
  assign unused_busy = FDivBusyE;
  assign accept  = state_q == IDLE && ReqValid && !Flush;
  assign timeout = cnt_q == CNTW'(TIMEOUT - 1);
  assign to_hit  = state_q == WAIT && !Flush && !FDivDoneE && timeout;
  assign abort   = Flush && (state_q == ISSUE || state_q == WAIT || state_q == CAPT);
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = Flush ? IDLE : WAIT;
      WAIT:    state_d = Flush ? IDLE : FDivDoneE ? CAPT : timeout ? RESP : WAIT;
      CAPT:    state_d = Flush ? IDLE : RESP;
      RESP:    state_d = (Flush || RspReady) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ReqReady   = state_q == IDLE && !reset;
    FDivStartE = state_q == ISSUE && !IntDivE;
    IDivStartE = state_q == ISSUE && IntDivE;
    RspValid   = state_q == RESP;
  end
  // FlushE is registered so it lands after ISSUE and never overlaps a start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      IntDivE        <= 1'b0;
      SqrtE          <= 1'b0;
      W64E           <= 1'b0;
      Funct3E        <= '0;
      ForwardedSrcAE <= '0;
      ForwardedSrcBE <= '0;
      RspTag         <= '0;
      RspData        <= '0;
      RspTimeout     <= 1'b0;
      FlushE         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      if (accept) begin
        IntDivE        <= ReqIsInt;
        SqrtE          <= ReqSqrt && !ReqIsInt;
        W64E           <= ReqW64;
        Funct3E        <= ReqFunct3;
        ForwardedSrcAE <= ReqSrcA;
        ForwardedSrcBE <= ReqSrcB;
        RspTag         <= ReqTag;
      end
      cnt_q  <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      FlushE <= abort || to_hit;
      if (to_hit) begin
        RspData    <= '0;
        RspTimeout <= 1'b1;
      end
      if (state_q == CAPT && !Flush) begin
        RspData    <= FIntDivResultM;
        RspTimeout <= 1'b0;
      end
    end
  end
`ifdef FDIVSQRT_REQUESTER_PERF_EN
  always_ff @(posedge clk)
    if (reset) begin
      PerfOps        <= '0;
      PerfWaitCycles <= '0;
    end else begin
      PerfOps        <= PerfOps + 32'(state_q == RESP && RspReady && !Flush && !RspTimeout);
      PerfWaitCycles <= PerfWaitCycles + 32'(state_q == WAIT);
    end
`endif
endmodule

// File: tb/tb_fdivsqrt_requester.sv
// tb_fdivsqrt_requester: directed checks of the requester protocol, with a short-timeout second instance.
module tb_fdivsqrt_requester;
  logic clk = 0, reset = 1;
  logic ReqValid = 0, ReqIsInt = 0, ReqSqrt = 0, ReqW64 = 0, Flush = 0;
  logic [2:0] ReqFunct3 = 0;
  logic [63:0] ReqSrcA = 0, ReqSrcB = 0, FIntDivResultM = 0;
  logic [3:0] ReqTag = 0;
  logic FDivBusyE = 1, FDivDoneE = 0, RspReady = 0;
  logic ReqReady, FDivStartE, IDivStartE, IntDivE, SqrtE, W64E, FlushE, RspValid, RspTimeout;
  logic [2:0] Funct3E;
  logic [63:0] ForwardedSrcAE, ForwardedSrcBE, RspData;
  logic [3:0] RspTag;
  logic t_ReqReady, t_FDivStartE, t_IDivStartE, t_IntDivE, t_SqrtE, t_W64E, t_FlushE, t_RspValid, t_RspTimeout;
  logic [2:0] t_Funct3E;
  logic [63:0] t_SrcAE, t_SrcBE, t_RspData;
  logic [3:0] t_RspTag;
  int n_chk = 0, n_fail = 0, n_starts;

  always #5 clk = ~clk;

  fdivsqrt_requester dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqIsInt(ReqIsInt),
    .ReqSqrt(ReqSqrt), .ReqFunct3(ReqFunct3), .ReqW64(ReqW64), .ReqSrcA(ReqSrcA), .ReqSrcB(ReqSrcB),
    .ReqTag(ReqTag), .Flush(Flush), .FDivStartE(FDivStartE), .IDivStartE(IDivStartE), .IntDivE(IntDivE),
    .SqrtE(SqrtE), .W64E(W64E), .Funct3E(Funct3E), .ForwardedSrcAE(ForwardedSrcAE),
    .ForwardedSrcBE(ForwardedSrcBE), .FlushE(FlushE), .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE),
    .FIntDivResultM(FIntDivResultM), .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspTag(RspTag), .RspTimeout(RspTimeout));

  fdivsqrt_requester #(.TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(t_ReqReady), .ReqIsInt(ReqIsInt),
    .ReqSqrt(ReqSqrt), .ReqFunct3(ReqFunct3), .ReqW64(ReqW64), .ReqSrcA(ReqSrcA), .ReqSrcB(ReqSrcB),
    .ReqTag(ReqTag), .Flush(Flush), .FDivStartE(t_FDivStartE), .IDivStartE(t_IDivStartE), .IntDivE(t_IntDivE),
    .SqrtE(t_SqrtE), .W64E(t_W64E), .Funct3E(t_Funct3E), .ForwardedSrcAE(t_SrcAE),
    .ForwardedSrcBE(t_SrcBE), .FlushE(t_FlushE), .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE),
    .FIntDivResultM(FIntDivResultM), .RspValid(t_RspValid), .RspReady(RspReady), .RspData(t_RspData),
    .RspTag(t_RspTag), .RspTimeout(t_RspTimeout));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a request in IDLE; returns at the ISSUE cycle
  task automatic req(input logic isint, input logic sqrt, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    ReqValid = 1; ReqIsInt = isint; ReqSqrt = sqrt; ReqFunct3 = f3;
    ReqSrcA = a; ReqSrcB = b; ReqTag = tag;
    @(negedge clk);
    ReqValid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk("rst_ready", ReqReady, 0);
    chk("rst_rspvalid", RspValid, 0);
    chk("rst_flush", FlushE, 0);
    chk("rst_start", FDivStartE | IDivStartE, 0);
    chk("rst_data", RspData, 0);
    reset = 0;
    cyc(1);
    chk("ready_after_rst", ReqReady, 1);

    // short op so the timeout instance holds a nonzero result first
    req(1, 0, 3'b100, 10, 3, 1);
    cyc(1);
    FDivDoneE = 1;
    cyc(1);
    FDivDoneE = 0; FIntDivResultM = 64'h77; RspReady = 1;
    cyc(1);
    chk("pre_to_data", t_RspData, 64'h77);
    cyc(1);
    RspReady = 0;
    chk("pre_to_idle", t_ReqReady, 1);

    // timeout: 8 WAIT cycles without done
    req(0, 0, 3'b000, 1, 2, 9);
    cyc(8);
    chk("to_still_wait", t_RspValid, 0);
    cyc(1);
    chk("to_flushe", t_FlushE, 1);
    chk("to_rspvalid", t_RspValid, 1);
    chk("to_flag", t_RspTimeout, 1);
    chk("to_data", t_RspData, 0);
    chk("to_tag", t_RspTag, 9);
    chk("to_main_waiting", RspValid, 0);
    cyc(1);
    chk("to_flushe_1cyc", t_FlushE, 0);
    chk("to_rsp_held", t_RspValid, 1);
    reset = 1; cyc(1); reset = 0; cyc(1);

    // integer divide, done 10 cycles after request
    req(1, 0, 3'b100, 100, 7, 3);
    chk("div_istart", IDivStartE, 1);
    chk("div_fstart", FDivStartE, 0);
    chk("div_intdiv", IntDivE, 1);
    chk("div_funct3", Funct3E, 3'b100);
    chk("div_srca", ForwardedSrcAE, 100);
    chk("div_srcb", ForwardedSrcBE, 7);
    chk("div_ready_busy", ReqReady, 0);
    n_starts = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      n_starts += int'(IDivStartE) + int'(FDivStartE);
      FDivDoneE = (i == 8);
    end
    cyc(1);
    FDivDoneE = 0; FIntDivResultM = 14; RspReady = 1;
    chk("div_one_pulse", n_starts, 0);
    chk("div_capt_novalid", RspValid, 0);
    cyc(1);
    chk("div_rspvalid", RspValid, 1);
    chk("div_data", RspData, 14);
    chk("div_tag", RspTag, 3);
    chk("div_timeout", RspTimeout, 0);
    cyc(1);
    RspReady = 0;
    chk("div_idle", ReqReady, 1);
    chk("div_rsp_done", RspValid, 0);

    // FP sqrt with response backpressure
    req(0, 1, 3'b000, 64'h4010_0000_0000_0000, 0, 5);
    chk("sq_fstart", FDivStartE, 1);
    chk("sq_istart", IDivStartE, 0);
    chk("sq_sqrt", SqrtE, 1);
    cyc(3);
    FDivDoneE = 1;
    cyc(1);
    FDivDoneE = 0; FIntDivResultM = 64'h4000_0000_0000_0000;
    chk("sq_sqrt_capt", SqrtE, 1);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      FIntDivResultM = 64'hBAD0 + 64'(i);
      chk("bp_valid", RspValid, 1);
      chk("bp_data", RspData, 64'h4000_0000_0000_0000);
      chk("bp_ready", ReqReady, 0);
      cyc(1);
    end
    RspReady = 1;
    cyc(1);
    RspReady = 0;
    chk("bp_idle", ReqReady, 1);
    chk("bp_novalid", RspValid, 0);

    // flush in WAIT cycle 4, later done ignored
    req(1, 0, 3'b101, 9, 2, 6);
    cyc(4);
    Flush = 1;
    cyc(1);
    Flush = 0;
    chk("fl_flushe", FlushE, 1);
    chk("fl_ready", ReqReady, 1);
    chk("fl_norsp", RspValid, 0);
    FDivDoneE = 1;
    cyc(1);
    FDivDoneE = 0;
    chk("fl_flushe_1cyc", FlushE, 0);
    cyc(2);
    chk("fl_late_done", RspValid, 0);
    chk("fl_still_idle", ReqReady, 1);

    // flush together with done
    req(1, 0, 3'b110, 9, 2, 7);
    cyc(2);
    Flush = 1; FDivDoneE = 1;
    cyc(1);
    Flush = 0; FDivDoneE = 0;
    chk("fd_flushe", FlushE, 1);
    chk("fd_norsp", RspValid, 0);
    cyc(1);
    chk("fd_flushe_1cyc", FlushE, 0);
    cyc(2);
    chk("fd_norsp_later", RspValid, 0);

    // flush in IDLE blocks a same-cycle request
    ReqValid = 1; Flush = 1;
    cyc(1);
    ReqValid = 0; Flush = 0;
    chk("idle_flush_ready", ReqReady, 1);
    chk("idle_flush_nostart", IDivStartE | FDivStartE, 0);

    // reset while in CAPT
    req(1, 0, 3'b100, 55, 5, 8);
    cyc(1);
    FDivDoneE = 1;
    cyc(1);
    FDivDoneE = 0; FIntDivResultM = 99; reset = 1;
    cyc(1);
    chk("rc_ready", ReqReady, 0);
    chk("rc_rsp", RspValid, 0);
    chk("rc_flushe", FlushE, 0);
    chk("rc_intdiv", IntDivE, 0);
    chk("rc_srca", ForwardedSrcAE, 0);
    chk("rc_data", RspData, 0);
    chk("rc_tag", RspTag, 0);
    reset = 0;
    cyc(1);
    chk("rc_ready_after", ReqReady, 1);
    chk("rc_no_flush", FlushE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fdivsqrt_requester.md
Name: fdivsqrt_requester

Overview:
- Issuing end of the divide/square-root start/busy/done protocol.
- Accepts one FP or integer div/rem/sqrt request at a time on a valid/ready port and drives the divider's E-stage start, operand and control inputs.
- Tracks busy/done, captures the M-stage result, and returns it with its tag on a valid/ready response port.
- Handles pipeline flush and a watchdog timeout. Sits between an issue queue or offload port and the divider.

Parameters:
XLEN, 64, integer operand/result width
TAGW, 4, request tag width
TIMEOUT, 128, max WAIT cycles before abort (must be ≥ 2)
CNTW, 8, watchdog counter width (2^CNTW > TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ReqValid  in  1  request valid
ReqReady  out  1  requester idle, can accept
ReqIsInt  in  1  1 = integer div/rem, 0 = FP
ReqSqrt  in  1  FP sqrt (ignored when ReqIsInt)
ReqFunct3  in  3  op funct3
ReqW64  in  1  RV64 W-form
ReqSrcA  in  XLEN  operand A
ReqSrcB  in  XLEN  operand B
ReqTag  in  TAGW  request tag
Flush  in  1  pipeline flush, abort current op
FDivStartE  out  1  FP start pulse
IDivStartE  out  1  integer start pulse
IntDivE  out  1  held op type
SqrtE  out  1  held sqrt flag
W64E  out  1  held W-form
Funct3E  out  3  held funct3
ForwardedSrcAE  out  XLEN  held operand A
ForwardedSrcBE  out  XLEN  held operand B
FlushE  out  1  one-cycle abort to divider
FDivBusyE  in  1  divider busy
FDivDoneE  in  1  divider done (E stage)
FIntDivResultM  in  XLEN  result, valid the cycle after FDivDoneE
RspValid  out  1  response valid
RspReady  in  1  consumer accepts
RspData  out  XLEN  result
RspTag  out  TAGW  tag of completed request
RspTimeout  out  1  response is a watchdog abort

Behaviour:
- States: IDLE, ISSUE, WAIT, CAPT, RESP. Reset → IDLE.
- Reset values: all outputs and holding registers 0. ReqReady=0 while reset is high, 1 on the first cycle after.
- IDLE: ReqReady=1. On ReqValid, capture Req* into holding registers → ISSUE.
- ISSUE:
  - Exactly one-cycle pulse: FDivStartE=~IsInt, IDivStartE=IsInt. Other E outputs are stable from ISSUE through CAPT.
  - Clear watchdog counter → WAIT.
- WAIT:
  - Counter increments each cycle.
  - FDivDoneE=1 → CAPT.
  - Counter reaches TIMEOUT-1 without done: pulse FlushE, set RspData=0 and RspTimeout=1 → RESP.
- CAPT: latch FIntDivResultM into RspData, RspTimeout=0 → RESP. Fixed latency: result is registered 2 cycles after FDivDoneE rises.
- RESP:
  - RspValid=1; RspData, RspTag and RspTimeout held stable.
  - RspValid&RspReady → IDLE. Back-to-back: the next request is accepted on the following cycle, so there is a minimum 1-cycle gap.
- Flush:
  - In ISSUE, WAIT or CAPT: pulse FlushE next cycle, go to IDLE, no response.
  - In RESP: response dropped, go to IDLE.
  - In IDLE: no effect; a same-cycle ReqValid is not accepted.
  - Flush wins over a simultaneous FDivDoneE or timeout.
- FDivDoneE outside WAIT is ignored. FDivBusyE is not required for sequencing; FDivBusyE=0 while in WAIT for more than 1 cycle is only a bench-checked anomaly.
- Reset mid-operation: immediate return to IDLE, no FlushE pulse (divider is reset by the same signal).
- Start pulses and FlushE are never asserted in the same cycle.

Optional Feature:
FDIVSQRT_REQUESTER_PERF_EN:
- Enabled adds two 32-bit outputs, reset to 0:
  - PerfOps: increments on each RESP handshake with RspTimeout=0.
  - PerfWaitCycles: increments each cycle in WAIT.
  - Both wrap at 2^32.
- Disabled: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Int DIV: ReqIsInt=1, Funct3=100, SrcA=100, SrcB=7, Tag=3; model asserts done 10 cycles later with result 14 → one IDivStartE pulse, RspValid with RspData=14 and RspTag=3, 2 cycles after done.
- FP sqrt: ReqIsInt=0, ReqSqrt=1 → FDivStartE pulse only, SqrtE=1 held until CAPT; result returned unchanged.
- Backpressure: RspReady low 5 cycles in RESP → RspValid/RspData stable, ReqReady=0 throughout, IDLE 1 cycle after handshake.
- Flush in WAIT cycle 4 → FlushE high for exactly 1 cycle, no RspValid, ReqReady=1 next cycle; a later done is ignored.
- Timeout with TIMEOUT=8, done never asserted → after 8 WAIT cycles FlushE pulse, RspValid=1, RspTimeout=1, RspData=0.
- Flush and FDivDoneE in the same cycle → no response, FlushE pulse; reset asserted in CAPT → IDLE, all outputs 0.
